// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch buffer
//
// Contents:
//   FETCH_PC_WIDTH / FETCH_INSTR_WIDTH - default field widths
//   NOP_INSTR                          - addi x0,x0,0, decode substitutes it when out_valid=0
//   fetch_entry_t                      - one buffered {pc, pc_plus, instr} triple
//   make_entry()                       - builds a fetch_entry_t from its three fields
package fetch_pkg;

  localparam int FETCH_PC_WIDTH    = 32;
  localparam int FETCH_INSTR_WIDTH = 32;

  localparam logic [FETCH_INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_WIDTH-1:0]    pc;
    logic [FETCH_PC_WIDTH-1:0]    pc_plus;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(
    input logic [FETCH_PC_WIDTH-1:0]    pc,
    input logic [FETCH_PC_WIDTH-1:0]    pc_plus,
    input logic [FETCH_INSTR_WIDTH-1:0] instr
  );
    fetch_entry_t e;
    e.pc      = pc;
    e.pc_plus = pc_plus;
    e.instr   = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// rtl/fetch_buffer_ram.sv - DEPTH x WIDTH register array, one write port, one async read port
//
// Ports:
//   clk       in   clock, write on rising edge
//   i_wr_en   in   write enable
//   i_wr_addr in   write address
//   i_wr_data in   write data
//   i_rd_addr in   read address
//   o_rd_data out  read data, combinational from i_rd_addr
//
// Contents are deliberately not reset; the owner tracks validity with its own count.
module fetch_buffer_ram #(
  parameter int WIDTH  = 96,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order FIFO of fetched {PC, PC+4, instr} triples feeding decode
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   flush        in   discard all entries at the next edge (redirect)
//   in_valid     in   fetch side presents an entry
//   in_ready     out  buffer has room (from registered count only)
//   in_PC        in   PC of fetched instruction
//   in_PC_Plus   in   PC+4 of fetched instruction
//   in_Instr     in   fetched instruction word
//   out_valid    out  head entry valid
//   out_ready    in   decode takes the head entry
//   out_PC       out  head PC (0 when empty)
//   out_PC_Plus  out  head PC+4 (0 when empty)
//   out_Instr    out  head instruction (0 when empty)
//   count        out  current occupancy
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_PC,
  input  logic [PC_WIDTH-1:0]        in_PC_Plus,
  input  logic [INSTR_WIDTH-1:0]     in_Instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_PC,
  output logic [PC_WIDTH-1:0]        out_PC_Plus,
  output logic [INSTR_WIDTH-1:0]     out_Instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * PC_WIDTH + INSTR_WIDTH;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wr_data;
  logic [ENTRY_W-1:0] w_rd_data;

  // Both handshakes depend only on the registered count, so out_ready never
  // reaches in_ready: a full buffer refuses a push even while it is popping.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign w_wr_data = {in_PC, in_PC_Plus, in_Instr};

  fetch_buffer_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push && !flush),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Flush outranks push and pop; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Decode never sees stale or X data: fields are forced to zero when empty.
  always_comb begin
    out_PC      = '0;
    out_PC_Plus = '0;
    out_Instr   = '0;
    if (out_valid) begin
      out_PC      = w_rd_data[ENTRY_W-1 -: PC_WIDTH];
      out_PC_Plus = w_rd_data[INSTR_WIDTH +: PC_WIDTH];
      out_Instr   = w_rd_data[INSTR_WIDTH-1:0];
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer against a queue model
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_PC = '0;
  logic [31:0] in_PC_Plus = '0;
  logic [31:0] in_Instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_PC;
  logic [31:0] out_PC_Plus;
  logic [31:0] out_Instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_entry_t model_q[$];

  always #5 clk = ~clk;

  fetch_buffer #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_PC       (in_PC),
    .in_PC_Plus  (in_PC_Plus),
    .in_Instr    (in_Instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_PC      (out_PC),
    .out_PC_Plus (out_PC_Plus),
    .out_Instr   (out_Instr),
    .count       (count)
  );

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid   = v;
    in_PC      = pc;
    in_PC_Plus = pc + 32'd4;
    in_Instr   = ins;
    out_ready  = rdy;
    flush      = fl;
  endtask

  // Advance one clock from a negedge to the next negedge, updating the model
  // from the handshake rules: room -> push, non-empty -> pop, flush wipes all.
  task automatic tick();
    bit do_push;
    bit do_pop;
    fetch_entry_t e;
    do_push = in_valid && (model_q.size() < DEPTH);
    do_pop  = out_ready && (model_q.size() > 0);
    e = make_entry(in_PC, in_PC_Plus, in_Instr);
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d out_valid=%0b required count=0 out_valid=0", count, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d required 3", count);
    end
    #2;
    rst = 1'b0;
    model_q.delete();
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_Instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: count=%0d out_valid=%0b out_Instr=%h required 0/0/0", count, out_valid, out_Instr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000_0000, 32'h0050_0093, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass: out_valid=%0b required 0", out_valid);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_PC !== 32'h0 || out_PC_Plus !== 32'h4 ||
        out_Instr !== 32'h0050_0093 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_entry: v=%0b pc=%h pcp=%h ins=%h cnt=%0d required 1/0/4/00500093/1",
               out_valid, out_PC, out_PC_Plus, out_Instr, count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d out_valid=%0b required 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill_backpressure();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h10, 32'hB000_0004, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d in_ready=%0b required 4/0", count, in_ready);
    end
    tick();
    tick();
    checks++;
    if (count !== 3'd4 || out_PC !== 32'h0) begin
      errors++;
      $display("FAIL fill_held: count=%0d head=%h required 4/0", count, out_PC);
    end
    drive(1'b1, 32'h10, 32'hB000_0004, 1'b1, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_PC !== 32'h0) begin
      errors++;
      $display("FAIL fill_pop_while_full: in_ready=%0b head=%h required 0/0", in_ready, out_PC);
    end
    tick();
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_after_pop: count=%0d in_ready=%0b required 3/1", count, in_ready);
    end
    drive(1'b1, 32'h10, 32'hB000_0004, 1'b0, 1'b0);
    tick();
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fill_held_accepted: count=%0d required 4", count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      exp_pc = 32'(i * 4);
      checks++;
      if (out_valid !== 1'b1 || out_PC !== exp_pc || out_PC_Plus !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL fill_drain[%0d]: v=%0b pc=%h required 1/%h", i, out_valid, out_PC, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] popped[$];
    int next_push;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h208, 32'hC000_0002, 1'b1, 1'b0);
    tick();
    checks++;
    if (count !== 3'd2 || out_PC !== 32'h204) begin
      errors++;
      $display("FAIL simul_push_pop: count=%0d head=%h required 2/204", count, out_PC);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    next_push = 0;
    for (int cyc = 0; cyc < 40 && popped.size() < 10; cyc++) begin
      if (next_push < 10) drive(1'b1, 32'(next_push * 4), 32'hD000_0000 + 32'(next_push), 1'b1, 1'b0);
      else drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      if (out_valid) popped.push_back(out_PC);
      if (in_valid && in_ready) next_push++;
      tick();
    end
    checks++;
    if (popped.size() != 10) begin
      errors++;
      $display("FAIL wrap_pop_count: popped=%0d required 10", popped.size());
    end
    for (int i = 0; i < popped.size() && i < 10; i++) begin
      checks++;
      if (popped[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL wrap_order[%0d]: pc=%h required %h", i, popped[i], 32'(i * 4));
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h8C, 32'hE000_0003, 1'b1, 1'b1);
    tick();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_PC !== 32'h0) begin
      errors++;
      $display("FAIL flush_priority: count=%0d out_valid=%0b pc=%h required 0/0/0", count, out_valid, out_PC);
    end
    drive(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_PC !== 32'h100 || out_Instr !== NOP_INSTR || count !== 3'd1) begin
      errors++;
      $display("FAIL flush_then_push: v=%0b pc=%h ins=%h cnt=%0d required 1/100/00000013/1",
               out_valid, out_PC, out_Instr, count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_empty_pop();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_PC !== 32'h0 ||
        out_PC_Plus !== 32'h0 || out_Instr !== 32'h0) begin
      errors++;
      $display("FAIL empty_pop: cnt=%0d v=%0b pc=%h pcp=%h ins=%h required all 0",
               count, out_valid, out_PC, out_PC_Plus, out_Instr);
    end
    drive(1'b1, 32'h300, 32'hF000_0000, 1'b1, 1'b0);
    tick();
    checks++;
    if (count !== 3'd1 || out_PC !== 32'h300) begin
      errors++;
      $display("FAIL empty_pop_pointer: cnt=%0d head=%h required 1/300", count, out_PC);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pend_pc;
    logic [31:0] pend_ins;
    logic        pend_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_pcp;
    logic [31:0] exp_ins;
    int          bad;
    pend_v = 1'b0;
    pend_pc = 32'h0;
    pend_ins = 32'h0;
    bad = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v   = 1'b1;
        pend_pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        pend_ins = $urandom;
      end
      drive(pend_v, pend_pc, pend_ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      #1;
      if (model_q.size() > 0) begin
        exp_pc = model_q[0].pc;
        exp_pcp = model_q[0].pc_plus;
        exp_ins = model_q[0].instr;
      end else begin
        exp_pc = 32'h0;
        exp_pcp = 32'h0;
        exp_ins = 32'h0;
      end
      checks++;
      if (count !== 3'(model_q.size()) || out_valid !== (model_q.size() != 0) ||
          in_ready !== (model_q.size() != DEPTH) || out_PC !== exp_pc ||
          out_PC_Plus !== exp_pcp || out_Instr !== exp_ins) begin
        errors++;
        if (bad < 10) begin
          $display("FAIL random[%0d]: cnt=%0d v=%0b rdy=%0b pc=%h pcp=%h ins=%h required cnt=%0d pc=%h pcp=%h ins=%h",
                   cyc, count, out_valid, in_ready, out_PC, out_PC_Plus, out_Instr,
                   model_q.size(), exp_pc, exp_pcp, exp_ins);
        end
        bad++;
      end
      if (flush || (model_q.size() < DEPTH)) pend_v = 1'b0;
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_back_to_back();
    test_flush();
    test_empty_pop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
